// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control unit: FSM states, EX/MEM shadow slots
// and the opcode constant used to flag loads.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    TRAP
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } shadow_t;

  // Invalid slots are kept all-zero so that "slot empty" is a whole-slot compare.
  function automatic shadow_t make_slot(logic v, logic [4:0] rd, logic [6:0] opcode);
    shadow_t s;
    s = '0;
    if (v) begin
      s.v  = 1'b1;
      s.rd = rd;
      s.ld = (opcode == OP_LOAD);
    end
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// Load-use detector: the load in EX writes a register that the ID instruction reads.
module load_use_det
  import pipe_ctrl_pkg::*;
(
  input  shadow_t    ex_s,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       lu
);

  assign lu = ex_s.v && ex_s.ld && (ex_s.rd != 5'd0) && id_valid &&
              ((ex_s.rd == id_rs1) || (ex_s.rd == id_rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/bubble/flush/freeze generation for the 5-stage core, with the
// drain-then-trap sequence for illegal instructions and two perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_ill,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             trap_ack,
  output logic             pc_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             freeze,
  output logic             trap_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e  state;
  shadow_t ex_s;
  shadow_t mem_s;
  logic    lu;

  load_use_det u_load_use_det (
    .ex_s     (ex_s),
    .id_valid (id_valid),
    .id_rs1   (id_rs1),
    .id_rs2   (id_rs2),
    .lu       (lu)
  );

  always_comb begin
    pc_stall     = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    freeze       = mem_busy;
    case (state)
      RUN: begin
        if (!mem_busy) begin
          // A redirect makes the ID instruction wrong-path, so its hazards do not matter.
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if ((id_valid && id_ill) || lu) begin
            pc_stall     = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
      end
      DRAIN: begin
        pc_stall     = 1'b1;
        id_ex_bubble = 1'b1;
      end
      TRAP: begin
        pc_stall     = 1'b1;
        id_ex_bubble = 1'b1;
        if_id_flush  = trap_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      trap_req  <= 1'b0;
      ex_s      <= '0;
      mem_s     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!mem_busy && !ex_redirect && id_valid && id_ill) state <= DRAIN;
        end
        DRAIN: begin
          if (!mem_busy && (ex_s == '0) && (mem_s == '0)) begin
            state    <= TRAP;
            trap_req <= 1'b1;
          end
        end
        TRAP: begin
          if (trap_ack) begin
            state    <= RUN;
            trap_req <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase

      if (!freeze) begin
        mem_s <= ex_s;
        ex_s  <= id_ex_bubble ? shadow_t'('0) : make_slot(id_valid, id_rd, id_opcode);
      end

      if (pc_stall || freeze) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush)        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios then random traffic,
// checked against a cycle-level behavioural model of the pipeline.
module tb_pipe_ctrl;

  localparam int CW = 4;
  localparam logic [6:0] LOAD_OP = 7'b0000011;
  localparam logic [6:0] ALU_OP  = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0, id_ill = 1'b0, ex_redirect = 1'b0;
  logic          mem_busy = 1'b0, trap_ack = 1'b0;
  logic [6:0]    id_opcode = 7'd0;
  logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic          pc_stall, id_ex_bubble, if_id_flush, freeze, trap_req;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_ill       (id_ill),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .trap_ack     (trap_ack),
    .pc_stall     (pc_stall),
    .id_ex_bubble (id_ex_bubble),
    .if_id_flush  (if_id_flush),
    .freeze       (freeze),
    .trap_req     (trap_req),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          stall, bubble, flush, frz, treq;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: 0 = running, 1 = waiting for EX/MEM to empty, 2 = trap pending.
  int            m_mode;
  bit            m_ex_v, m_ex_ld, m_mem_v;
  logic [4:0]    m_ex_rd;
  logic [CW-1:0] m_sc, m_fc;

  task automatic chk(input string name, input longint act, input longint req);
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ex_v = 0; m_ex_ld = 0; m_mem_v = 0; m_ex_rd = 0; m_sc = 0; m_fc = 0;
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, advance the model.
  task automatic stp(input bit v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input bit ill, input bit redir, input bit busy, input bit ack);
    exp_t e;
    bit hz, st, bu, fl, fz;
    int nmode;
    @(negedge clk);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_ill = ill; ex_redirect = redir; mem_busy = busy; trap_ack = ack;
    hz = m_ex_v && m_ex_ld && (m_ex_rd != 0) && v && (m_ex_rd == r1 || m_ex_rd == r2);
    st = 0; bu = 0; fl = 0; fz = busy; nmode = m_mode;
    case (m_mode)
      0: if (!busy) begin
           if (redir) begin fl = 1; bu = 1; end
           else if (v && ill) begin st = 1; bu = 1; nmode = 1; end
           else if (hz) begin st = 1; bu = 1; end
         end
      1: begin st = 1; bu = 1; if (!busy && !m_ex_v && !m_mem_v) nmode = 2; end
      default: begin st = 1; bu = 1; if (ack) begin fl = 1; nmode = 0; end end
    endcase
    e.stall = st; e.bubble = bu; e.flush = fl; e.frz = fz; e.treq = (m_mode == 2);
    e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (st || fz) m_sc = m_sc + 1'b1;
    if (fl) m_fc = m_fc + 1'b1;
    if (!fz) begin
      m_mem_v = m_ex_v;
      m_ex_v  = v && !bu;
      m_ex_rd = rd;
      m_ex_ld = (op == LOAD_OP);
    end
    m_mode = nmode;
  endtask

  task automatic idle();
    stp(0, ALU_OP, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit check_trap);
    @(negedge clk);
    #3;
    id_valid = 0; id_ill = 0; ex_redirect = 0; mem_busy = 0; trap_ack = 0;
    if (check_trap) chk("trap_req_before_reset", trap_req, 1);
    rst_n = 1'b0;
    #1;
    vectors++;
    chk("reset_trap_req", trap_req, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_pc_stall", pc_stall, 0);
    chk("reset_bubble", id_ex_bubble, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      chk("pc_stall", pc_stall, e.stall);
      chk("id_ex_bubble", id_ex_bubble, e.bubble);
      chk("if_id_flush", if_id_flush, e.flush);
      chk("freeze", freeze, e.frz);
      chk("trap_req", trap_req, e.treq);
      chk("stall_cnt", stall_cnt, e.sc);
      chk("flush_cnt", flush_cnt, e.fc);
    end
  end

  initial begin
    model_reset();
    do_reset(0);

    // load-use, then the same pattern with rd = x0
    stp(1, LOAD_OP, 0, 0, 5, 0, 0, 0, 0);
    stp(1, ALU_OP, 5, 1, 6, 0, 0, 0, 0);
    stp(1, ALU_OP, 5, 1, 6, 0, 0, 0, 0);
    idle();
    stp(1, LOAD_OP, 0, 0, 0, 0, 0, 0, 0);
    stp(1, ALU_OP, 0, 1, 6, 0, 0, 0, 0);
    idle();

    // redirect coinciding with a load-use
    stp(1, LOAD_OP, 0, 0, 5, 0, 0, 0, 0);
    stp(1, ALU_OP, 5, 1, 6, 0, 1, 0, 0);
    idle();

    // memory wait during a load-use
    stp(1, LOAD_OP, 0, 0, 5, 0, 0, 0, 0);
    repeat (3) stp(1, ALU_OP, 5, 1, 6, 0, 0, 1, 0);
    stp(1, ALU_OP, 5, 1, 6, 0, 0, 0, 0);
    stp(1, ALU_OP, 5, 1, 6, 0, 0, 0, 0);
    idle();

    // illegal instruction with EX and MEM occupied
    stp(1, ALU_OP, 0, 0, 7, 0, 0, 0, 0);
    stp(1, ALU_OP, 0, 0, 8, 0, 0, 0, 0);
    stp(1, ALU_OP, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) stp(1, ALU_OP, 0, 0, 0, 1, 0, 0, 0);
    repeat (4) stp(1, ALU_OP, 0, 0, 0, 1, 0, 0, 0);
    stp(1, ALU_OP, 0, 0, 0, 1, 0, 0, 1);
    idle();

    // reset while in TRAP
    stp(1, ALU_OP, 0, 0, 7, 0, 0, 0, 0);
    stp(1, ALU_OP, 0, 0, 8, 0, 0, 0, 0);
    stp(1, ALU_OP, 0, 0, 0, 1, 0, 0, 0);
    repeat (3) stp(1, ALU_OP, 0, 0, 0, 1, 0, 0, 0);
    do_reset(1);

    // counter wrap: 17 stall cycles on a 4-bit counter
    repeat (17) stp(0, ALU_OP, 0, 0, 0, 0, 0, 1, 0);
    idle();
    #3;
    vectors++;
    chk("stall_cnt_wrap", stall_cnt, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      stp(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 40) ? LOAD_OP : ALU_OP,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 30));
    end
    idle();
    repeat (3) @(negedge clk);
    #4;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
